// File: rtl/pdp8_pkg.sv
// rtl/pdp8_pkg.sv - shared widths, reset vector and strobe indices for the PC/field unit
package pdp8_pkg;

    localparam int PDP8_WIDTH      = 12;
    localparam int PDP8_FIELD_BITS = 3;
    localparam logic [11:0] PDP8_RESET_VECTOR = 12'o0200;

    // Bit positions of the strobes inside the edge-detect vector.
    typedef enum int {
        STB_LD     = 0,
        STB_FETCH  = 1,
        STB_CK     = 2,
        STB_CDF    = 3,
        STB_CIF    = 4,
        STB_RMF    = 5,
        STB_INTACK = 6
    } strobe_e;

    localparam int NUM_STROBES = 7;

endpackage

// File: rtl/edge_rise.sv
// rtl/edge_rise.sv - single-bit rising-edge detector with registered history
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset, clears the history bit
//   d     - level input
//   rise  - high while d is high and was low on the previous clock
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    // History clears in reset, so a level held through reset release
    // still produces one pulse on the first clock afterwards.
    assign rise = d & ~prev_q;

endmodule

// File: rtl/pc_field_unit.sv
// rtl/pc_field_unit.sv - program counter and memory-field registers driven by edge strobes
// Ports:
//   SYSCLK, RESET            - clock, asynchronous active-low reset
//   IN, FLD                  - jump target, field operand for CDF/CIF
//   LD, FETCH, CK, LATCH     - PC strobes (LD > FETCH > CK), LATCH qualifies CK
//   CDF, CIF, RMF, INTACK    - field strobes
//   PC, PCLAT, PCLATIF       - current PC, PC/IF captured at fetch
//   IF, DF, IB, SF, INHIBIT  - field registers, save field, interrupt inhibit
module pc_field_unit
    import pdp8_pkg::*;
#(
    parameter int WIDTH      = PDP8_WIDTH,
    parameter int FIELD_BITS = PDP8_FIELD_BITS,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PDP8_RESET_VECTOR)
) (
    input  logic                    SYSCLK,
    input  logic                    RESET,
    input  logic [WIDTH-1:0]        IN,
    input  logic [FIELD_BITS-1:0]   FLD,
    input  logic                    LD,
    input  logic                    FETCH,
    input  logic                    CK,
    input  logic                    LATCH,
    input  logic                    CDF,
    input  logic                    CIF,
    input  logic                    RMF,
    input  logic                    INTACK,
    output logic [WIDTH-1:0]        PC,
    output logic [WIDTH-1:0]        PCLAT,
    output logic [FIELD_BITS-1:0]   IF,
    output logic [FIELD_BITS-1:0]   DF,
    output logic [FIELD_BITS-1:0]   IB,
    output logic [FIELD_BITS-1:0]   PCLATIF,
    output logic [2*FIELD_BITS-1:0] SF,
    output logic                    INHIBIT
);

    logic [NUM_STROBES-1:0] strobe_raw;
    logic [NUM_STROBES-1:0] stb;

    always_comb begin
        strobe_raw             = '0;
        strobe_raw[STB_LD]     = LD;
        strobe_raw[STB_FETCH]  = FETCH;
        strobe_raw[STB_CK]     = CK;
        strobe_raw[STB_CDF]    = CDF;
        strobe_raw[STB_CIF]    = CIF;
        strobe_raw[STB_RMF]    = RMF;
        strobe_raw[STB_INTACK] = INTACK;
    end

    for (genvar g = 0; g < NUM_STROBES; g++) begin : g_edge
        edge_rise u_edge (
            .clk   (SYSCLK),
            .rst_n (RESET),
            .d     (strobe_raw[g]),
            .rise  (stb[g])
        );
    end

    logic [WIDTH-1:0]        pc_q, pc_d;
    logic [WIDTH-1:0]        pclat_q, pclat_d;
    logic [FIELD_BITS-1:0]   pclatif_q, pclatif_d;
    logic [FIELD_BITS-1:0]   if_q, if_d;
    logic [FIELD_BITS-1:0]   df_q, df_d;
    logic [FIELD_BITS-1:0]   ib_q, ib_d;
    logic [2*FIELD_BITS-1:0] sf_q, sf_d;
    logic                    inhibit_q, inhibit_d;

    always_comb begin
        pc_d      = pc_q;
        pclat_d   = pclat_q;
        pclatif_d = pclatif_q;
        if_d      = if_q;
        df_d      = df_q;
        ib_d      = ib_q;
        sf_d      = sf_q;
        inhibit_d = inhibit_q;

        // PC path: lower-priority edges in the same cycle are dropped.
        if (stb[STB_LD]) begin
            pc_d = IN;
        end else if (stb[STB_FETCH]) begin
            pclat_d   = pc_q;
            pclatif_d = if_q;
            pc_d      = pc_q + 1'b1;
        end else if (stb[STB_CK]) begin
            if (LATCH) begin
                pclat_d   = pc_q;
                pclatif_d = if_q;
            end
            pc_d = pc_q + 1'b1;
        end

        // Field path: INTACK wins outright; otherwise the jump commits the
        // pending IB into IF, and a same-cycle CIF/RMF re-arms the inhibit.
        // Explicit FLD operands (CIF/CDF) take precedence over RMF restore.
        if (stb[STB_INTACK]) begin
            sf_d      = {if_q, df_q};
            if_d      = '0;
            ib_d      = '0;
            df_d      = '0;
            inhibit_d = 1'b0;
        end else begin
            if (stb[STB_LD]) begin
                if_d      = ib_q;
                inhibit_d = 1'b0;
            end
            if (stb[STB_RMF]) begin
                ib_d      = sf_q[2*FIELD_BITS-1:FIELD_BITS];
                df_d      = sf_q[FIELD_BITS-1:0];
                inhibit_d = 1'b1;
            end
            if (stb[STB_CIF]) begin
                ib_d      = FLD;
                inhibit_d = 1'b1;
            end
            if (stb[STB_CDF]) begin
                df_d = FLD;
            end
        end
    end

    always_ff @(posedge SYSCLK or negedge RESET) begin
        if (!RESET) begin
            pc_q      <= RESET_VECTOR;
            pclat_q   <= '0;
            pclatif_q <= '0;
            if_q      <= '0;
            df_q      <= '0;
            ib_q      <= '0;
            sf_q      <= '0;
            inhibit_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            pclat_q   <= pclat_d;
            pclatif_q <= pclatif_d;
            if_q      <= if_d;
            df_q      <= df_d;
            ib_q      <= ib_d;
            sf_q      <= sf_d;
            inhibit_q <= inhibit_d;
        end
    end

    assign PC      = pc_q;
    assign PCLAT   = pclat_q;
    assign PCLATIF = pclatif_q;
    assign IF      = if_q;
    assign DF      = df_q;
    assign IB      = ib_q;
    assign SF      = sf_q;
    assign INHIBIT = inhibit_q;

endmodule

// File: tb/tb_pc_field_unit.sv
// tb/tb_pc_field_unit.sv - scoreboard bench for pc_field_unit
module tb_pc_field_unit;

    logic        SYSCLK = 1'b0;
    logic        RESET  = 1'b1;
    logic [11:0] IN     = '0;
    logic [2:0]  FLD    = '0;
    logic        LD = 0, FETCH = 0, CK = 0, LATCH = 0;
    logic        CDF = 0, CIF = 0, RMF = 0, INTACK = 0;
    logic [11:0] PC, PCLAT;
    logic [2:0]  IF, DF, IB, PCLATIF;
    logic [5:0]  SF;
    logic        INHIBIT;

    pc_field_unit dut (
        .SYSCLK (SYSCLK), .RESET (RESET), .IN (IN), .FLD (FLD),
        .LD (LD), .FETCH (FETCH), .CK (CK), .LATCH (LATCH),
        .CDF (CDF), .CIF (CIF), .RMF (RMF), .INTACK (INTACK),
        .PC (PC), .PCLAT (PCLAT), .IF (IF), .DF (DF), .IB (IB),
        .PCLATIF (PCLATIF), .SF (SF), .INHIBIT (INHIBIT)
    );

    always #5 SYSCLK = ~SYSCLK;

    typedef struct {
        int pc, pclat, pclatif, ifr, df, ib, sf, inh;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state (PDP-8 style registers as plain integers)
    int m_pc, m_pclat, m_pclatif, m_if, m_df, m_ib, m_sf, m_inh;
    bit m_prev[7];

    function automatic exp_t snap();
        exp_t e;
        e.pc = m_pc; e.pclat = m_pclat; e.pclatif = m_pclatif; e.ifr = m_if;
        e.df = m_df; e.ib = m_ib; e.sf = m_sf; e.inh = m_inh;
        return e;
    endfunction

    function automatic void model_reset();
        m_pc = 'o200; m_pclat = 0; m_pclatif = 0; m_if = 0;
        m_df = 0; m_ib = 0; m_sf = 0; m_inh = 0;
        for (int i = 0; i < 7; i++) m_prev[i] = 1'b0;
    endfunction

    // One clock of behaviour: strobes count only when they go from low to high.
    function automatic void model_clock(bit ld, bit fe, bit ck, bit lat, bit cdf,
                                        bit cif, bit rmf, bit ia, int in_v, int fld_v);
        bit lvl[7];
        bit e[7];
        exp_t o;
        lvl = '{ld, fe, ck, cdf, cif, rmf, ia};
        for (int i = 0; i < 7; i++) begin
            e[i] = lvl[i] && !m_prev[i];
            m_prev[i] = lvl[i];
        end
        o = snap();
        if (e[0]) m_pc = in_v;
        else if (e[1] || (e[2])) begin
            if (e[1] || lat) begin
                m_pclat = o.pc;
                m_pclatif = o.ifr;
            end
            m_pc = (o.pc + 1) % 4096;
        end
        if (e[6]) begin
            m_sf = o.ifr * 8 + o.df;
            m_if = 0; m_ib = 0; m_df = 0; m_inh = 0;
        end else begin
            if (e[0]) begin m_if = o.ib; m_inh = 0; end
            if (e[5]) begin m_ib = o.sf / 8; m_df = o.sf % 8; m_inh = 1; end
            if (e[4]) begin m_ib = fld_v; m_inh = 1; end
            if (e[3]) m_df = fld_v;
        end
    endfunction

    task automatic step(input bit rst, input bit ld, input bit fe, input bit ck,
                        input bit lat, input bit cdf, input bit cif, input bit rmf,
                        input bit ia, input int in_v, input int fld_v);
        @(negedge SYSCLK);
        RESET = rst; LD = ld; FETCH = fe; CK = ck; LATCH = lat;
        CDF = cdf; CIF = cif; RMF = rmf; INTACK = ia;
        IN = 12'(in_v); FLD = 3'(fld_v);
        if (!rst) model_reset();
        else model_clock(ld, fe, ck, lat, cdf, cif, rmf, ia, in_v, fld_v);
        exp_q.push_back(snap());
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset between clock edges; outputs must follow without a clock.
    task automatic do_reset();
        @(negedge SYSCLK);
        #2;
        model_reset();
        exp_q.push_back(snap());
        exp_q.push_back(snap());
        RESET = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0o expected %0o (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge SYSCLK or negedge RESET);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("PC", int'(PC), e.pc);
                chk("PCLAT", int'(PCLAT), e.pclat);
                chk("PCLATIF", int'(PCLATIF), e.pclatif);
                chk("IF", int'(IF), e.ifr);
                chk("DF", int'(DF), e.df);
                chk("IB", int'(IB), e.ib);
                chk("SF", int'(SF), e.sf);
                chk("INHIBIT", int'(INHIBIT), e.inh);
            end
        end
    end

    initial begin : driver
        model_reset();
        #2;
        exp_q.push_back(snap());
        exp_q.push_back(snap());
        RESET = 1'b0;

        // FETCH held high across reset release acts once
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // CIF then jump commits the field
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3);
        idle();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 'o400, 0);
        idle();
        // increment wrap with latch
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 'o7777, 0);
        idle();
        step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle();
        // IF=2, DF=5, interrupt, restore
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
        idle();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 'o100, 0);
        idle();
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle();
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        idle();
        // simultaneous PC strobes; INTACK overrides CIF
        step(1, 1, 1, 1, 1, 0, 0, 0, 0, 'o1234, 0);
        idle();
        step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 6);
        idle();
        // LD with CIF in the same cycle
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4);
        idle();
        step(1, 1, 0, 0, 0, 0, 1, 0, 0, 'o1234, 7);
        idle();
        // reset mid-sequence with PC=1234, IF=4
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(1,
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 2) == 0), 1'($urandom),
                     ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                     int'($urandom_range(0, 4095)), int'($urandom_range(0, 7)));
            end
        end
        idle();
        @(posedge SYSCLK);
        #3;
        vectors++;
        chk("QUEUE_EMPTY", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_field_unit.md
PC_FIELD_UNIT -- requirements
Module: pc_field_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 12, PC/address width.
REQ-002 SHALL have parameter FIELD_BITS, default 3, memory-field register width.
REQ-003 SHALL have parameter RESET_VECTOR, default 12'o0200, PC value after reset.
REQ-004 SHALL have port SYSCLK  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port RESET  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port IN  in  WIDTH  jump target.
REQ-007 SHALL have port FLD  in  FIELD_BITS  field operand for CDF/CIF.
REQ-008 SHALL have ports LD, FETCH, CK, LATCH  in  1 each  jump load, fetch, skip/increment, latch qualifier for CK.
REQ-009 SHALL have ports CDF, CIF, RMF, INTACK  in  1 each  change data field, change instruction field, restore memory field, interrupt acknowledge.
REQ-010 SHALL have ports PC, PCLAT  out  WIDTH  current PC, PC latched at fetch.
REQ-011 SHALL have ports IF, DF, IB  out  FIELD_BITS  instruction field, data field, instruction buffer.
REQ-012 SHALL have port PCLATIF  out  FIELD_BITS  IF latched with PCLAT.
REQ-013 SHALL have port SF  out  2*FIELD_BITS  save field {IF,DF}.
REQ-014 SHALL have port INHIBIT  out  1  interrupt inhibit, CIF/RMF pending until jump.

Function
REQ-015 Every strobe (LD, FETCH, CK, CDF, CIF, RMF, INTACK) SHALL act only on its rising edge: high now, low in previous SYSCLK cycle; a held-high strobe acts once.
REQ-016 Strobe effects SHALL be visible on outputs one SYSCLK edge after the sampled rising edge; no combinational input-to-output paths.
REQ-017 PC priority per cycle: LD > FETCH > CK; lower-priority edges in the same cycle SHALL be discarded, not deferred.
REQ-018 LD edge: PC<=IN; IF<=IB; INHIBIT<=0.
REQ-019 FETCH edge: PCLAT<=PC; PCLATIF<=IF; PC<=PC+1.
REQ-020 CK edge: PC<=PC+1; PCLAT<=PC and PCLATIF<=IF only if LATCH=1.
REQ-021 Increment SHALL wrap modulo 2^WIDTH (all-ones -> 0) without changing IF.
REQ-022 CIF edge: IB<=FLD; INHIBIT<=1; IF unchanged until next LD edge.
REQ-023 CDF edge: DF<=FLD immediately; CDF and CIF together SHALL both apply.
REQ-024 RMF edge: IB<=SF[2*FIELD_BITS-1:FIELD_BITS]; DF<=SF[FIELD_BITS-1:0]; INHIBIT<=1.
REQ-025 INTACK edge: SF<={IF,DF}; IF, IB, DF<=0; INHIBIT<=0; SHALL override CDF/CIF/RMF/LD field effects in the same cycle.
REQ-026 INTACK with LD same cycle: PC<=IN, IF<=0.
REQ-027 LD with CIF same cycle: IF<=old IB, IB<=FLD, INHIBIT<=1.
REQ-028 PC-path strobes SHALL be independent of field-path strobes except as stated in REQ-018, REQ-025 to REQ-027.

Reset
REQ-029 RESET low SHALL immediately force PC=RESET_VECTOR; PCLAT, PCLATIF, IF, DF, IB, SF=0; INHIBIT=0; all strobe history=0.
REQ-030 Reset mid-operation SHALL abort pending edges; strobe held high through reset release SHALL act on the first post-reset edge.

Structure
REQ-031 WIDTH/FIELD_BITS defaults and RESET_VECTOR SHALL live in shared package pdp8_pkg.
REQ-032 Rising-edge detection SHALL use one reusable sub-module edge_rise (registered previous value, async active-low reset), one instance per strobe.

Verification
REQ-033 Reset release, hold FETCH high 5 cycles -> PC 0200->0201 once, PCLAT=0200, PCLATIF=0.
REQ-034 FLD=3, CIF edge, then LD edge IN=0400 -> IB=3 and INHIBIT=1 after CIF, IF=3, PC=0400, INHIBIT=0 after LD.
REQ-035 PC=7777, CK with LATCH=1 -> PC=0000, IF unchanged, PCLAT=7777.
REQ-036 IF=2, DF=5, INTACK -> SF=25 octal, IF/DF/IB=0; then RMF -> IB=2, DF=5, INHIBIT=1.
REQ-037 LD+FETCH+CK same cycle IN=1234 -> PC=1234, PCLAT unchanged; INTACK+CIF same cycle -> IB=0, INHIBIT=0.
REQ-038 RESET low mid-sequence with PC=1234, IF=4 -> all outputs at reset values without waiting for SYSCLK.
